reg_display_scanner: RTL and testbench

Reader side of the register-file debug (VGA) port. It walks the selection index over all architectural registers, snapshots each value and emits one formatted text line per register (e.g. "x05:DEADBEEF") into the VGA character buffer through a valid/ready write handshake. It sits between the CPU register file's debug read port and the text-mode VGA frame buffer.

---
 rtl/reg_display_pkg.sv | 19 +
 rtl/hex_ascii_digit.sv | 17 +
 rtl/reg_display_scanner.sv | 150 +++++++++++++++
 tb/tb_reg_display_scanner.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_display_pkg.sv
// Shared constants and FSM encoding for the register display scanner.
package reg_display_pkg;

    localparam int LINE_CHARS = 12;

    localparam logic [7:0] CH_X     = 8'h78;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LATCH,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hex_ascii_digit.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex_ascii_digit
    import reg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = CH_ZERO + {4'b0000, nibble};
        end else begin
            ascii = CH_A + {4'b0000, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/reg_display_scanner.sv
// Walks the register-file debug port and writes one "xNN:HHHHHHHH" text line
// per register into the VGA character buffer over a valid/ready handshake.
module reg_display_scanner
    import reg_display_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int LINE_STRIDE = 16,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic              iContinuous,
    output logic [4:0]        oVGASelect,
    input  logic [31:0]       iVGARead,
    output logic [ADDR_W-1:0] oCharAddr,
    output logic [7:0]        oCharData,
    output logic              oCharValid,
    input  logic              iCharReady,
    output logic              oBusy,
    output logic              oFrameDone
);

    state_t      state, state_next;
    logic [4:0]  idx, idx_next;
    logic [3:0]  pos, pos_next;
    logic [31:0] shadow, shadow_next;

    logic [1:0]        tens_val;
    logic [4:0]        ones_val;
    logic [3:0]        nibble;
    logic [7:0]        hex_char;
    logic [7:0]        char_sel;
    logic [ADDR_W-1:0] addr_sel;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= ST_IDLE;
            idx    <= '0;
            pos    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            pos    <= pos_next;
            shadow <= shadow_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        pos_next    = pos;
        shadow_next = shadow;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    idx_next   = '0;
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: state_next = ST_LATCH;
            ST_LATCH: begin
                // One snapshot per line keeps a line from tearing mid-emit.
                shadow_next = iVGARead;
                pos_next    = '0;
                state_next  = ST_EMIT;
            end
            ST_EMIT: begin
                if (iCharReady) begin
                    if (pos == 4'(LINE_CHARS - 1)) begin
                        if (idx == 5'(NUM_REGS - 1)) begin
                            state_next = ST_DONE;
                        end else begin
                            idx_next   = idx + 5'd1;
                            state_next = ST_SELECT;
                        end
                    end else begin
                        pos_next = pos + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (iContinuous) begin
                    idx_next   = '0;
                    state_next = ST_SELECT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tens_val = 2'd0;
        ones_val = idx;
        if (idx >= 5'd30) begin
            tens_val = 2'd3;
            ones_val = idx - 5'd30;
        end else if (idx >= 5'd20) begin
            tens_val = 2'd2;
            ones_val = idx - 5'd20;
        end else if (idx >= 5'd10) begin
            tens_val = 2'd1;
            ones_val = idx - 5'd10;
        end
    end

    always_comb begin
        case (pos)
            4'd4:    nibble = shadow[31:28];
            4'd5:    nibble = shadow[27:24];
            4'd6:    nibble = shadow[23:20];
            4'd7:    nibble = shadow[19:16];
            4'd8:    nibble = shadow[15:12];
            4'd9:    nibble = shadow[11:8];
            4'd10:   nibble = shadow[7:4];
            4'd11:   nibble = shadow[3:0];
            default: nibble = 4'h0;
        endcase
    end

    hex_ascii_digit u_hex_digit (
        .nibble(nibble),
        .ascii (hex_char)
    );

    always_comb begin
        case (pos)
            4'd0:    char_sel = CH_X;
            4'd1:    char_sel = CH_ZERO + {6'b000000, tens_val};
            4'd2:    char_sel = CH_ZERO + {3'b000, ones_val};
            4'd3:    char_sel = CH_COLON;
            default: char_sel = hex_char;
        endcase
    end

    // Address arithmetic is done at ADDR_W bits so it wraps naturally.
    assign addr_sel = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(LINE_STRIDE) + ADDR_W'(pos);

    assign oCharValid = (state == ST_EMIT);
    assign oCharAddr  = oCharValid ? addr_sel : '0;
    assign oCharData  = oCharValid ? char_sel : 8'h00;
    assign oVGASelect = idx;
    assign oBusy      = (state != ST_IDLE);
    assign oFrameDone = (state == ST_DONE);

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed self-checking bench for reg_display_scanner.
module tb_reg_display_scanner;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic        iContinuous;
    logic        iCharReady;
    logic        start2;
    logic        cont2;
    logic [4:0]  sel1, sel2;
    logic [31:0] read1, read2;
    logic [9:0]  addr1, addr2;
    logic [7:0]  data1, data2;
    logic        valid1, valid2, busy1, busy2, done1, done2;

    logic [31:0] regs [32];
    logic [7:0]  mem  [1024];
    logic [7:0]  mem2 [1024];
    logic [9:0]  addr_log [$];

    int check_count = 0;
    int pass_count  = 0;
    int wr_count    = 0;
    int wr2_count   = 0;
    int done_count  = 0;
    int hold_violations = 0;
    int cyc         = 0;

    logic       prev_stall = 1'b0;
    logic [9:0] prev_addr  = '0;
    logic [7:0] prev_data  = '0;

    assign read1 = regs[sel1];
    assign read2 = regs[sel2];

    always #5 iCLK = ~iCLK;

    reg_display_scanner dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iContinuous(iContinuous),
        .oVGASelect(sel1), .iVGARead(read1), .oCharAddr(addr1), .oCharData(data1),
        .oCharValid(valid1), .iCharReady(iCharReady), .oBusy(busy1), .oFrameDone(done1)
    );

    reg_display_scanner #(.BASE_ADDR(1020)) dut_wrap (
        .iCLK(iCLK), .iRST(iRST), .iStart(start2), .iContinuous(cont2),
        .oVGASelect(sel2), .iVGARead(read2), .oCharAddr(addr2), .oCharData(data2),
        .oCharValid(valid2), .iCharReady(iCharReady), .oBusy(busy2), .oFrameDone(done2)
    );

    // Mid-cycle recorder of accepted writes, frame-done pulses and hold stability.
    always @(negedge iCLK) begin
        cyc++;
        if (prev_stall && (!valid1 || addr1 !== prev_addr || data1 !== prev_data))
            hold_violations++;
        prev_stall = valid1 && !iCharReady;
        prev_addr  = addr1;
        prev_data  = data1;
        if (valid1 && iCharReady) begin
            mem[addr1] = data1;
            wr_count++;
            addr_log.push_back(addr1);
        end
        if (valid2 && iCharReady) begin
            mem2[addr2] = data2;
            wr2_count++;
        end
        if (done1) done_count++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        step(1);
        iStart = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
    endtask

    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge iCLK);
            n++;
            if (done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input logic [9:0] target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge iCLK);
            if (valid1 && addr1 == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int w0;
        iRST = 1'b1;
        step(3);
        @(negedge iCLK);
        check_count++;
        if ({sel1, addr1, data1, valid1, busy1, done1} !== '0)
            $display("[TB] FAIL reset_outputs: got %h need 0", {sel1, addr1, data1, valid1, busy1, done1});
        else pass_count++;
        step(1);
        iRST = 1'b0;
        step(2);

        pulse_start();
        wait_addr(10'd37, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL reset_reach37: got timeout need addr 37");
        else pass_count++;
        #1 iRST = 1'b1;
        @(negedge iCLK);
        check_count++;
        if ({sel1, addr1, data1, valid1, busy1, done1} !== '0)
            $display("[TB] FAIL reset_midframe: got %h need 0", {sel1, addr1, data1, valid1, busy1, done1});
        else pass_count++;
        step(1);
        iRST = 1'b0;
        w0 = wr_count;
        step(20);
        check_count++;
        if (wr_count !== w0) $display("[TB] FAIL reset_no_writes: got %0d writes need 0", wr_count - w0);
        else pass_count++;
        @(negedge iCLK);
        check_count++;
        if (busy1 !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b need 0", busy1);
        else pass_count++;
        step(1);
    endtask

    task automatic test_single_frame();
        string l2 = "x02:00003FFC";
        string l5 = "x05:DEADBEEF";
        bit ok;
        int n, w0, d0;
        clear_mem();
        w0 = wr_count;
        d0 = done_count;
        pulse_start();
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL frame_done_seen: got timeout need pulse");
        else pass_count++;
        check_count++;
        if (n !== 449) $display("[TB] FAIL frame_latency: got %0d cycles need 449", n);
        else pass_count++;
        step(3);
        check_count++;
        if (wr_count - w0 !== 384) $display("[TB] FAIL frame_writes: got %0d need 384", wr_count - w0);
        else pass_count++;
        check_count++;
        if (done_count - d0 !== 1) $display("[TB] FAIL frame_done_pulses: got %0d need 1", done_count - d0);
        else pass_count++;
        for (int i = 0; i < 12; i++) begin
            check_count++;
            if (mem[32 + i] !== 8'(l2[i]))
                $display("[TB] FAIL line2_char%0d: got %h need %h", i, mem[32 + i], 8'(l2[i]));
            else pass_count++;
            check_count++;
            if (mem[80 + i] !== 8'(l5[i]))
                $display("[TB] FAIL line5_char%0d: got %h need %h", i, mem[80 + i], 8'(l5[i]));
            else pass_count++;
        end
    endtask

    task automatic test_backpressure();
        string l0 = "x00:0123ABCD";
        bit ok;
        int n, w0, h0;
        clear_mem();
        addr_log.delete();
        w0 = wr_count;
        h0 = hold_violations;
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            iCharReady = (c % 4 == 3);
            step(1);
            if (wr_count - w0 >= 12) break;
        end
        iCharReady = 1'b1;
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL bp_done_seen: got timeout need pulse");
        else pass_count++;
        step(1);
        check_count++;
        if (hold_violations !== h0)
            $display("[TB] FAIL bp_hold_stable: got %0d violations need 0", hold_violations - h0);
        else pass_count++;
        check_count++;
        if (wr_count - w0 !== 384) $display("[TB] FAIL bp_writes: got %0d need 384", wr_count - w0);
        else pass_count++;
        for (int i = 0; i < 12; i++) begin
            check_count++;
            if (mem[i] !== 8'(l0[i]))
                $display("[TB] FAIL bp_line0_char%0d: got %h need %h", i, mem[i], 8'(l0[i]));
            else pass_count++;
            check_count++;
            if (addr_log.size() <= i || addr_log[i] !== 10'(i))
                $display("[TB] FAIL bp_addr_order%0d: got %0d need %0d", i,
                         (addr_log.size() > i) ? int'(addr_log[i]) : -1, i);
            else pass_count++;
        end
    endtask

    task automatic test_snapshot();
        string l7 = "x07:11111111";
        bit ok;
        int n;
        clear_mem();
        pulse_start();
        wait_addr(10'd118, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL snap_reach_pos6: got timeout need addr 118");
        else pass_count++;
        #1 regs[7] = 32'h22222222;
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL snap_done_seen: got timeout need pulse");
        else pass_count++;
        step(1);
        for (int i = 0; i < 12; i++) begin
            check_count++;
            if (mem[112 + i] !== 8'(l7[i]))
                $display("[TB] FAIL snap_line7_char%0d: got %h need %h", i, mem[112 + i], 8'(l7[i]));
            else pass_count++;
        end
        regs[7] = 32'h11111111;
    endtask

    task automatic test_continuous();
        bit ok, found;
        int n, m, w0;
        iContinuous = 1'b1;
        pulse_start();
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL cont_first_done: got timeout need pulse");
        else pass_count++;
        m = 0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iCLK);
            m++;
            if (valid1) begin
                found = 1'b1;
                break;
            end
        end
        check_count++;
        if (!found || m > 3) $display("[TB] FAIL cont_restart_latency: got %0d cycles need <=3", m);
        else pass_count++;
        check_count++;
        if ({addr1, data1} !== {10'd0, 8'h78})
            $display("[TB] FAIL cont_first_write: got addr %0d data %h need addr 0 data 78", addr1, data1);
        else pass_count++;
        step(1);
        iContinuous = 1'b0;
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL cont_second_done: got timeout need pulse");
        else pass_count++;
        step(2);
        @(negedge iCLK);
        check_count++;
        if (busy1 !== 1'b0) $display("[TB] FAIL cont_idle_busy: got %b need 0", busy1);
        else pass_count++;
        step(1);
        w0 = wr_count;
        step(20);
        check_count++;
        if (wr_count !== w0) $display("[TB] FAIL cont_stays_idle: got %0d writes need 0", wr_count - w0);
        else pass_count++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int n, c0, w0, d0;
        w0 = wr_count;
        d0 = done_count;
        pulse_start();
        c0 = cyc;
        wait_addr(10'd160, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL busy_reach_line10: got timeout need addr 160");
        else pass_count++;
        step(1);
        pulse_start();
        wait_done(n, ok);
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL busy_done_seen: got timeout need pulse");
        else pass_count++;
        step(1);
        check_count++;
        if (cyc - c0 !== 449) $display("[TB] FAIL busy_frame_length: got %0d cycles need 449", cyc - c0);
        else pass_count++;
        step(2);
        check_count++;
        if (wr_count - w0 !== 384) $display("[TB] FAIL busy_writes: got %0d need 384", wr_count - w0);
        else pass_count++;
        check_count++;
        if (done_count - d0 !== 1) $display("[TB] FAIL busy_done_pulses: got %0d need 1", done_count - d0);
        else pass_count++;
        @(negedge iCLK);
        check_count++;
        if (busy1 !== 1'b0) $display("[TB] FAIL busy_returns_idle: got %b need 0", busy1);
        else pass_count++;
        step(1);
    endtask

    task automatic test_wrap();
        string l0 = "x00:0123ABCD";
        bit ok;
        int w2;
        clear_mem();
        w2 = wr2_count;
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge iCLK);
            if (done2) begin
                ok = 1'b1;
                break;
            end
        end
        check_count++;
        if (ok !== 1'b1) $display("[TB] FAIL wrap_done_seen: got timeout need pulse");
        else pass_count++;
        step(2);
        check_count++;
        if (wr2_count - w2 !== 384) $display("[TB] FAIL wrap_writes: got %0d need 384", wr2_count - w2);
        else pass_count++;
        for (int i = 0; i < 12; i++) begin
            check_count++;
            if (mem2[(1020 + i) % 1024] !== 8'(l0[i]))
                $display("[TB] FAIL wrap_line0_char%0d: got %h need %h", i,
                         mem2[(1020 + i) % 1024], 8'(l0[i]));
            else pass_count++;
        end
        check_count++;
        if ({mem2[12], mem2[13], mem2[14]} !== {8'h78, 8'h30, 8'h31})
            $display("[TB] FAIL wrap_line1_start: got %h need 783031", {mem2[12], mem2[13], mem2[14]});
        else pass_count++;
        check_count++;
        if (busy2 !== 1'b0) $display("[TB] FAIL wrap_idle_busy: got %b need 0", busy2);
        else pass_count++;
    endtask

    initial begin
        iRST        = 1'b1;
        iStart      = 1'b0;
        iContinuous = 1'b0;
        iCharReady  = 1'b1;
        start2      = 1'b0;
        cont2       = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 | i;
        regs[0] = 32'h0123ABCD;
        regs[2] = 32'h00003FFC;
        regs[5] = 32'hDEADBEEF;
        regs[7] = 32'h11111111;
        clear_mem();

        test_reset();
        test_single_frame();
        test_backpressure();
        test_snapshot();
        test_continuous();
        test_start_while_busy();
        test_wrap();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
